// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : 4-digit common-anode seven-segment scanner showing sign/tens/ones
//            BCD and an optional hex op code, with per-frame input snapshots.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd,
    input  logic [11:0] instr_code,
    input  logic        show_op,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int                  c_PCNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_PCNT_W-1:0] c_PCNT_MAX  = c_PCNT_W'(REFRESH_DIV - 1);
    localparam logic [c_PCNT_W-1:0] c_BLANK_END = c_PCNT_W'(BLANK_CYC);
    localparam logic [6:0]          c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0]          c_SEG_DASH  = 7'b0111111;
    localparam logic [6:0]          c_SEG_E     = 7'b0000110;

    logic [c_PCNT_W-1:0] r_pcnt;
    logic [1:0]          r_idx;
    logic [11:0]         r_snap_bcd;
    logic [3:0]          r_snap_op;
    logic                r_snap_show;
    logic                r_first;

    logic                w_tick;
    logic                w_frame_end;
    logic                w_load;
    logic [6:0]          w_digit_seg;
    logic [3:0]          w_an_nxt;
    logic [6:0]          w_seg_nxt;
    logic                w_unused;

    // Only the op-code nibble is ever displayed.
    assign w_unused = ^instr_code[7:0];

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick      = (r_pcnt == c_PCNT_MAX);
    assign w_frame_end = w_tick && (r_idx == 2'd3);
    assign w_load      = r_first || w_frame_end;

    always_comb begin
        w_digit_seg = c_SEG_BLANK;
        case (r_idx)
            2'd0: begin
                w_digit_seg = (r_snap_bcd[3:0] > 4'd9) ? c_SEG_E : hex_to_seg(r_snap_bcd[3:0]);
            end
            2'd1: begin
                // An out-of-range tens digit is an error, so it is never suppressed.
                if (r_snap_bcd[7:4] > 4'd9)
                    w_digit_seg = c_SEG_E;
                else if (r_snap_bcd[7:4] != 4'd0)
                    w_digit_seg = hex_to_seg(r_snap_bcd[7:4]);
            end
            2'd2: begin
                if (r_snap_bcd[11:8] == 4'd1)
                    w_digit_seg = c_SEG_DASH;
                else if (r_snap_bcd[11:8] != 4'd0)
                    w_digit_seg = c_SEG_E;
            end
            default: begin
                if (r_snap_show)
                    w_digit_seg = hex_to_seg(r_snap_op);
            end
        endcase
    end

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = c_SEG_BLANK;
        if (r_pcnt >= c_BLANK_END) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = w_digit_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt      <= '0;
            r_idx       <= 2'd0;
            r_snap_bcd  <= 12'd0;
            r_snap_op   <= 4'd0;
            r_snap_show <= 1'b0;
            r_first     <= 1'b1;
            an          <= 4'b1111;
            seg         <= c_SEG_BLANK;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pcnt <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
            if (w_load) begin
                r_snap_bcd  <= bcd;
                r_snap_op   <= instr_code[11:8];
                r_snap_show <= show_op;
            end
            r_first    <= 1'b0;
            an         <= w_an_nxt;
            seg        <= w_seg_nxt;
            dp         <= 1'b1;
            frame_done <= w_frame_end;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed bench for seg_scan_driver with hand-computed digit patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int REFRESH_DIV = 8;
    localparam int BLANK_CYC   = 2;

    localparam logic [6:0] c_S_BL = 7'b1111111;
    localparam logic [6:0] c_S_DA = 7'b0111111;
    localparam logic [6:0] c_S_E  = 7'b0000110;
    localparam logic [6:0] c_S_A  = 7'b0001000;
    localparam logic [6:0] c_S_1  = 7'b1111001;
    localparam logic [6:0] c_S_3  = 7'b0110000;
    localparam logic [6:0] c_S_4  = 7'b0011001;
    localparam logic [6:0] c_S_5  = 7'b0010010;
    localparam logic [6:0] c_S_7  = 7'b1111000;
    localparam logic [6:0] c_S_9  = 7'b0010000;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd;
    logic [11:0] instr_code;
    logic        show_op;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_checks;
    int n_fails;
    int pos;
    int pulse_cnt;

    seg_scan_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd        (bcd),
        .instr_code (instr_code),
        .show_op    (show_op),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        pos = (pos + 1) % (4 * REFRESH_DIV);
    endtask

    // segs = {slot3, slot2, slot1, slot0}; pos is the frame position the outputs reflect.
    task automatic check_now(input logic [27:0] segs);
        int         s;
        int         p;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        s = pos / REFRESH_DIV;
        p = pos % REFRESH_DIV;
        if (p < BLANK_CYC) begin
            e_an  = 4'b1111;
            e_seg = c_S_BL;
        end else begin
            e_an  = ~(4'b0001 << s);
            e_seg = segs[s*7 +: 7];
        end
        check_val($sformatf("an@%0d", pos), {28'd0, an}, {28'd0, e_an});
        check_val($sformatf("seg@%0d", pos), {25'd0, seg}, {25'd0, e_seg});
        check_val($sformatf("dp@%0d", pos), {31'd0, dp}, 32'd1);
        check_val($sformatf("frame_done@%0d", pos), {31'd0, frame_done},
                  (pos == 4 * REFRESH_DIV - 1) ? 32'd1 : 32'd0);
        if (frame_done === 1'b1)
            pulse_cnt++;
    endtask

    task automatic run(input logic [27:0] segs, input int n);
        repeat (n) begin
            step();
            check_now(segs);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        pulse_cnt  = 0;
        pos        = 0;
        rst_n      = 1'b0;
        bcd        = 12'h015;
        instr_code = 12'h000;
        show_op    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_an", {28'd0, an}, 32'hF);
        check_val("rst_seg", {25'd0, seg}, 32'h7F);
        check_val("rst_dp", {31'd0, dp}, 32'd1);
        check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);

        rst_n = 1'b1;
        pos   = 4 * REFRESH_DIV - 1;

        // 0x015, op hidden: 5, 1, blank sign, blank op
        run({c_S_BL, c_S_BL, c_S_1, c_S_5}, 32);
        // Mid-slot-1 change must not disturb the current frame
        run({c_S_BL, c_S_BL, c_S_1, c_S_5}, 10);
        bcd = 12'h009;
        run({c_S_BL, c_S_BL, c_S_1, c_S_5}, 22);
        // 0x009: leading zero suppressed; new inputs arrive just before the boundary edge
        run({c_S_BL, c_S_BL, c_S_BL, c_S_9}, 31);
        bcd        = 12'h104;
        show_op    = 1'b1;
        instr_code = 12'hA45;
        run({c_S_BL, c_S_BL, c_S_BL, c_S_9}, 1);
        // 0x104 with op A; a change one cycle after the boundary waits a frame
        run({c_S_A, c_S_DA, c_S_BL, c_S_4}, 32);
        bcd = 12'h2FA;
        run({c_S_A, c_S_DA, c_S_BL, c_S_4}, 32);
        // 0x2FA: every numeric slot shows E
        run({c_S_A, c_S_E, c_S_E, c_S_E}, 32);
        run({c_S_A, c_S_E, c_S_E, c_S_E}, 21);

        // One-cycle reset during slot 2
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_an", {28'd0, an}, 32'hF);
        check_val("midrst_seg", {25'd0, seg}, 32'h7F);
        check_val("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        check_val("midrst_dp", {31'd0, dp}, 32'd1);
        bcd        = 12'h037;
        instr_code = 12'h312;
        rst_n      = 1'b1;
        pos        = 4 * REFRESH_DIV - 1;

        // Restart at slot 0 with the freshly captured 0x037 / op 3
        run({c_S_3, c_S_BL, c_S_3, c_S_7}, 32);
        run({c_S_3, c_S_BL, c_S_3, c_S_7}, 32);

        check_val("pulse_count", pulse_cnt, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed 4-digit seven-segment driver sitting directly downstream of the ALU decoder. Consumes the decoder's 12-bit sign/tens/ones BCD word and its 12-bit instruction code. Scans the board's common-anode display with a free-running refresh prescaler. Inputs are snapshotted once per scan frame so a digit never tears mid-frame, and anodes are blanked briefly at each digit change to suppress ghosting.

## Interface
- REFRESH_DIV, 100000, clock cycles per digit slot (≥ BLANK_CYC+2); 1 kHz per digit at 100 MHz
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- bcd  in  12  [11:8] sign (0000 positive, 0001 negative), [7:4] tens, [3:0] ones
- instr_code  in  12  [11:8] op code, [7:4] a, [3:0] b; only [11:8] is displayed
- show_op  in  1  1: leftmost digit shows op code in hex; 0: leftmost digit blank
- an  out  4  anode enables, active-low; an[0] is the rightmost digit
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; held 1
- frame_done  out  1  one-cycle pulse per completed scan frame

## Operation
- Prescaler pcnt counts 0..REFRESH_DIV-1 and wraps. A slot tick occurs when pcnt==REFRESH_DIV-1.
- Slot index idx (2 bits) advances 0→1→2→3→0 on each tick.
- Snapshot register {snap_bcd, snap_op, snap_show} loads on either of two events:
  - the first cycle after rst_n is sampled high (first-frame flag);
  - the tick with idx==3, i.e. the frame boundary.
- Between loads, input changes have no effect on the display.
- Digit content by idx:
  - 0: ones, from snap_bcd[3:0].
  - 1: tens, from snap_bcd[7:4]. Blank if 0 (leading-zero suppression).
  - 2: sign, from snap_bcd[11:8]. 0000 → blank; 0001 → '-'; any other value → 'E'.
  - 3: op code, shown as hex 0-F if snap_show=1, otherwise blank.
- BCD digits 10-15 in the tens or ones slot display 'E'. Tens is not suppressed in that case.
- Patterns, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 4 = 0011001, 5 = 0010010, A = 0001000, E = 0000110
  - '-' = 0111111, blank = 1111111
  - all other hex digits use the standard patterns.
- Anodes:
  - When pcnt < BLANK_CYC: an = 1111 and seg = blank.
  - Otherwise: an = ~(1<<idx), and seg carries the pattern for idx.
  - A blank digit still drives its anode, with seg = 1111111.
- frame_done pulses at each frame-boundary snapshot load. It does not pulse on the first-frame load after reset.

## Timing
- an, seg, dp and frame_done are registered. Each reflects pcnt, idx and the snapshot with exactly one clock of latency.
- Reset (rst_n=0 at a rising edge):
  - pcnt=0, idx=0, snapshot=0, first-frame flag=1;
  - an=1111, seg=1111111, dp=1, frame_done=0.
- Reset asserted mid-slot or mid-frame aborts the scan immediately, with the same values on the next edge. No partial digit is shown after reset.
- The first-frame load happens in the first cycle after reset release. Displayed data becomes valid on the first unblanked cycle of slot 0.
- Frame period is 4·REFRESH_DIV cycles. frame_done is high in the first cycle of idx==0 after each wrap.
- An input change coinciding with the boundary tick is captured. A change one cycle later waits a full frame.

## Test plan
- Reset, then bcd=0x015, show_op=0 (REFRESH_DIV=8, BLANK_CYC=2) → slot 0 shows an=1110, seg=0010010; slot 1 shows an=1101, seg=1111001; slots 2-3 show seg blank. Each slot has 2 blank cycles with an=1111 first.
- bcd=0x104, show_op=1, instr_code=0xA45 → slot 0 '4'; slot 1 blank (leading zero); slot 2 '-' (0111111); slot 3 'A' (0001000).
- Change bcd from 0x015 to 0x009 mid-slot-1 → the rest of the frame still shows 1 and 5. The next frame, after frame_done, shows blank tens and 9 ones.
- bcd=0x2FA → sign slot 'E', tens slot 'E', ones slot 'E'.
- Assert rst_n=0 for 1 cycle during slot 2 → next edge an=1111, seg=1111111, frame_done=0. After release, scanning restarts at slot 0 with the freshly loaded snapshot.
- Run 3 frames → frame_done pulses exactly 3 times, 32 cycles apart, each lasting 1 cycle. dp stays 1 throughout.
